// File: rtl/chnl_pkg.sv
// Shared constants and types for the channel ingress buffer.
// Holds: default data width, stall counter type, pointer-width helper.
// No logic; imported by chnl_fifo_mem and chnl_slave_fifo.
package chnl_pkg;

  localparam int CHNL_DW_DEFAULT = 32;
  localparam int STALL_CNT_W     = 16;

  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Pointer width for a power-of-two DEPTH (>= 2); pointers wrap naturally.
  function automatic int chnl_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/chnl_fifo_mem.sv
// Dual-port storage array: synchronous write, asynchronous (combinational) read.
// Latency: written word readable after the write edge; read path has zero latency.
// Backpressure: none here; the caller gates wr_en_i.
// Ports: clk_i, wr_en_i/wr_addr_i/wr_data_i (write side), rd_addr_i/rd_data_o (read side).
module chnl_fifo_mem
  import chnl_pkg::*;
#(
  parameter int DW    = CHNL_DW_DEFAULT,
  parameter int DEPTH = 32,
  parameter int AW    = chnl_ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  // Contents are deliberately not reset; validity is tracked by the count.
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = r_mem[rd_addr_i];

endmodule

// File: rtl/chnl_slave_fifo.sv
// Channel ingress buffer: first-word-fall-through FIFO between a channel and the arbiter.
// Latency: a word pushed at edge N is at the head after edge N; no empty bypass.
// Backpressure: ch_ready_o = en_i && !full, independent of out_ready_i (full never accepts).
// Ports: clk_i, rstn_i (async active-low), en_i; ch_data_i/ch_valid_i/ch_ready_o upstream;
//   out_data_o/out_valid_o/out_ready_i downstream; margin_o (free entries), almost_full_o;
//   stall_clr_i/stall_cnt_o stall counter, present only with CHNL_STALL_CNT_EN defined.
module chnl_slave_fifo
  import chnl_pkg::*;
#(
  parameter int DW       = CHNL_DW_DEFAULT,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   en_i,
  input  logic [DW-1:0]          ch_data_i,
  input  logic                   ch_valid_i,
  output logic                   ch_ready_o,
  output logic [DW-1:0]          out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [$clog2(DEPTH):0] margin_o,
  output logic                   almost_full_o,
  input  logic                   stall_clr_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int PW = chnl_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign ch_ready_o    = en_i && (r_count != DEPTH_C);
  assign out_valid_o   = (r_count != '0);
  assign w_push        = ch_valid_i && ch_ready_o;
  assign w_pop         = out_valid_o && out_ready_i;
  assign margin_o      = DEPTH_C - r_count;
  assign almost_full_o = (r_count >= AF_C);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      // Push and pop together leave the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  chnl_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (w_push),
    .wr_addr_i (r_wr_ptr),
    .wr_data_i (ch_data_i),
    .rd_addr_i (r_rd_ptr),
    .rd_data_o (out_data_o)
  );

`ifdef CHNL_STALL_CNT_EN
  stall_cnt_t r_stall_cnt;

  // Clear wins over increment; the counter holds at all-ones.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stall_cnt <= '0;
    end else if (stall_clr_i) begin
      r_stall_cnt <= '0;
    end else if (ch_valid_i && !ch_ready_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  logic w_unused_stall_clr;
  assign w_unused_stall_clr = stall_clr_i;
  assign stall_cnt_o        = '0;
`endif

endmodule

// File: tb/tb_chnl_slave_fifo.sv
// Directed self-checking bench for chnl_slave_fifo at DEPTH=8 (AF_LEVEL=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Stall counter expectations follow CHNL_STALL_CNT_EN.
module tb_chnl_slave_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          en_i;
  logic [DW-1:0] ch_data_i;
  logic          ch_valid_i;
  logic          ch_ready_o;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [3:0]    margin_o;
  logic          almost_full_o;
  logic          stall_clr_i;
  logic [15:0]   stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  chnl_slave_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .en_i          (en_i),
    .ch_data_i     (ch_data_i),
    .ch_valid_i    (ch_valid_i),
    .ch_ready_o    (ch_ready_o),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .margin_o      (margin_o),
    .almost_full_o (almost_full_o),
    .stall_clr_i   (stall_clr_i),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Push words base, base+1, ... with the output side stalled.
  task automatic push_n(input int n, input logic [DW-1:0] base);
    out_ready_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      ch_valid_i = 1'b1;
      ch_data_i  = base + DW'(i);
      tick();
    end
    ch_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; en_i = 1'b1; ch_valid_i = 1'b0; ch_data_i = '0;
    out_ready_i = 1'b0; stall_clr_i = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid_o); end
    n_checks++;
    if (margin_o !== 4'd8) begin n_fail++; $display("FAIL reset_margin: got %0d want 8", margin_o); end
    n_checks++;
    if (almost_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %0b want 0", almost_full_o); end
    n_checks++;
    if (ch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_en1: got %0b want 1", ch_ready_o); end
    n_checks++;
    if (stall_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt_o); end
    en_i = 1'b0; #1;
    n_checks++;
    if (ch_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_en0: got %0b want 0", ch_ready_o); end
    en_i = 1'b1;
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    out_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ch_valid_i = 1'b1;
      ch_data_i  = DW'(i + 1);
      n_checks++;
      if (ch_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %0b want 1", i, ch_ready_o); end
      tick();
      n_checks++;
      if (margin_o !== 4'(DEPTH - (i + 1))) begin
        n_fail++; $display("FAIL fill_margin[%0d]: got %0d want %0d", i, margin_o, DEPTH - (i + 1));
      end
      n_checks++;
      if (almost_full_o !== ((i + 1) >= 4)) begin
        n_fail++; $display("FAIL fill_af[%0d]: got %0b want %0b", i, almost_full_o, (i + 1) >= 4);
      end
    end
    n_checks++;
    if (ch_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %0b want 0", ch_ready_o); end
    ch_valid_i = 1'b0;
  endtask

  task automatic test_drain();
    out_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== DW'(i + 1)) begin
        n_fail++; $display("FAIL drain[%0d]: got v=%0b d=%0h want v=1 d=%0h", i, out_valid_o, out_data_o, i + 1);
      end
      tick();
    end
    out_ready_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %0b want 0", out_valid_o); end
    n_checks++;
    if (margin_o !== 4'd8) begin n_fail++; $display("FAIL drain_margin: got %0d want 8", margin_o); end
  endtask

  task automatic test_stream();
    push_n(3, 32'h100);
    out_ready_i = 1'b1;
    ch_valid_i  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ch_data_i = 32'h103 + DW'(i);
      n_checks++;
      if (out_data_o !== 32'h100 + DW'(i)) begin
        n_fail++; $display("FAIL stream_head[%0d]: got %0h want %0h", i, out_data_o, 32'h100 + i);
      end
      tick();
      n_checks++;
      if (margin_o !== 4'd5) begin n_fail++; $display("FAIL stream_margin[%0d]: got %0d want 5", i, margin_o); end
    end
    ch_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 32'h114 + DW'(i)) begin
        n_fail++; $display("FAIL stream_tail[%0d]: got v=%0b d=%0h want v=1 d=%0h", i, out_valid_o, out_data_o, 32'h114 + i);
      end
      tick();
    end
    out_ready_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %0b want 0", out_valid_o); end
  endtask

  task automatic test_full_pop();
    push_n(DEPTH, 32'h200);
    ch_valid_i  = 1'b1;
    ch_data_i   = 32'hDEAD;
    out_ready_i = 1'b1;
    n_checks++;
    if (ch_ready_o !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready_before: got %0b want 0", ch_ready_o); end
    tick();
    n_checks++;
    if (margin_o !== 4'd1) begin n_fail++; $display("FAIL fullpop_margin: got %0d want 1", margin_o); end
    n_checks++;
    if (ch_ready_o !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready_after: got %0b want 1", ch_ready_o); end
    ch_valid_i = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      n_checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 32'h200 + DW'(i)) begin
        n_fail++; $display("FAIL fullpop_drain[%0d]: got v=%0b d=%0h want v=1 d=%0h", i, out_valid_o, out_data_o, 32'h200 + i);
      end
      tick();
    end
    out_ready_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %0b want 0", out_valid_o); end
  endtask

  task automatic test_enable();
    push_n(5, 32'h300);
    en_i = 1'b0;
    ch_valid_i = 1'b1;
    ch_data_i  = 32'hBAD;
    out_ready_i = 1'b1;
    #1;
    n_checks++;
    if (ch_ready_o !== 1'b0) begin n_fail++; $display("FAIL en0_ready: got %0b want 0", ch_ready_o); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 32'h300 + DW'(i)) begin
        n_fail++; $display("FAIL en0_drain[%0d]: got v=%0b d=%0h want v=1 d=%0h", i, out_valid_o, out_data_o, 32'h300 + i);
      end
      tick();
    end
    n_checks++;
    if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL en0_empty: got %0b want 0", out_valid_o); end
    out_ready_i = 1'b0;
    en_i = 1'b1;
    ch_data_i = 32'h3AA;
    #1;
    n_checks++;
    if (ch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reen_ready: got %0b want 1", ch_ready_o); end
    tick();
    ch_valid_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h3AA || margin_o !== 4'd7) begin
      n_fail++; $display("FAIL reen_push: got v=%0b d=%0h m=%0d want v=1 d=3aa m=7", out_valid_o, out_data_o, margin_o);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    push_n(6, 32'h400);
    n_checks++;
    if (margin_o !== 4'd2) begin n_fail++; $display("FAIL midrst_pre_margin: got %0d want 2", margin_o); end
    ch_valid_i = 1'b1;
    ch_data_i  = 32'h4FF;
    #2;
    rstn_i = 1'b0;
    #1;
    n_checks++;
    if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b want 0", out_valid_o); end
    n_checks++;
    if (margin_o !== 4'd8) begin n_fail++; $display("FAIL midrst_margin: got %0d want 8", margin_o); end
    ch_valid_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    push_n(1, 32'h500);
    n_checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h500 || margin_o !== 4'd7) begin
      n_fail++; $display("FAIL midrst_after: got v=%0b d=%0h m=%0d want v=1 d=500 m=7", out_valid_o, out_data_o, margin_o);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] exp_cnt;
`ifdef CHNL_STALL_CNT_EN
    exp_cnt = 16'd10;
`else
    exp_cnt = 16'd0;
`endif
    stall_clr_i = 1'b1;
    tick();
    stall_clr_i = 1'b0;
    n_checks++;
    if (stall_cnt_o !== 16'd0) begin n_fail++; $display("FAIL stall_pre_clr: got %0d want 0", stall_cnt_o); end
    en_i = 1'b0;
    ch_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    ch_valid_i = 1'b0;
    n_checks++;
    if (stall_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", stall_cnt_o, exp_cnt); end
    tick();
    n_checks++;
    if (stall_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL stall_hold: got %0d want %0d", stall_cnt_o, exp_cnt); end
    stall_clr_i = 1'b1;
    ch_valid_i  = 1'b1;
    tick();
    stall_clr_i = 1'b0;
    ch_valid_i  = 1'b0;
    n_checks++;
    if (stall_cnt_o !== 16'd0) begin n_fail++; $display("FAIL stall_clr: got %0d want 0", stall_cnt_o); end
    en_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_pop();
    test_enable();
    test_reset_mid();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
